// File: rtl/pkt_admit_pkg.sv
// pkt_admit_pkg
//   Shared types and constants for the packet admission stage.
//   - admit_state_t : per-packet admission FSM state.
//   - beat_t        : one beat on the streaming bus (data, sop, eop, empty).
//   - EMPTY_W       : width of the empty-symbol count (64 symbols per beat).
//   - BEAT_DATA_W   : payload width carried in beat_t. The top-level DATA_W
//                     parameter must equal this value.
package pkt_admit_pkg;

   localparam int EMPTY_W     = 6;
   localparam int BEAT_DATA_W = 512;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } admit_state_t;

   typedef struct packed {
      logic [BEAT_DATA_W-1:0] data;
      logic                   sop;
      logic                   eop;
      logic [EMPTY_W-1:0]     empty;
   } beat_t;

endpackage

// File: rtl/pkt_admit_outreg.sv
// pkt_admit_outreg
//   One-entry valid/ready pipeline register. It is loaded when load is high,
//   holds while out_valid & !out_ready, and clears to all-zero when it drains
//   without a new load. The register gives 1-cycle latency at full throughput.
// Ports
//   clk, rst_l  : clock, asynchronous active-low reset
//   load        : capture in_beat this cycle (only asserted while ready is high)
//   in_beat     : beat to capture
//   ready       : register can accept a beat this cycle
//   out_valid   : register holds a beat
//   out_beat    : held beat (zero when empty)
//   out_ready   : downstream accepts the held beat
module pkt_admit_outreg
   import pkt_admit_pkg::*;
(
   input  logic  clk,
   input  logic  rst_l,
   input  logic  load,
   input  beat_t in_beat,
   output logic  ready,
   output logic  out_valid,
   output beat_t out_beat,
   input  logic  out_ready
);

   logic  valid_q, valid_d;
   beat_t beat_q,  beat_d;

   always_comb begin
      valid_d = valid_q;
      beat_d  = beat_q;
      if (load) begin
         valid_d = 1'b1;
         beat_d  = in_beat;
      end else if (out_ready) begin
         valid_d = 1'b0;
         beat_d  = '0;
      end
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else begin
         valid_q <= valid_d;
         beat_q  <= beat_d;
      end
   end

   assign ready     = !valid_q | out_ready;
   assign out_valid = valid_q;
   assign out_beat  = beat_q;

endmodule

// File: rtl/pkt_admit_drop.sv
// pkt_admit_drop
//   Packet-granular admission stage in front of a packet FIFO. At each SOP the
//   FIFO fill_level is compared with ADMIT_LIMIT; a packet that fits is
//   forwarded intact through a one-beat register, otherwise the whole packet
//   is consumed and discarded so the FIFO can never overflow mid-packet.
//   The decision is taken once per packet and never revised.
// Ports
//   clk, rst_l                          : clock, asynchronous active-low reset
//   in_data/valid/ready/sop/eop/empty   : upstream beat interface
//   out_data/valid/ready/sop/eop/empty  : downstream (FIFO) interface
//   fill_level                          : FIFO occupancy in beats
//   pkt_cnt / drop_cnt / err_cnt        : admitted / dropped packets, framing errors
// Configuration
//   PKT_ADMIT_STATS_EN : when defined the three counters are live; otherwise
//                        they are not built and read 32'd0.
module pkt_admit_drop
   import pkt_admit_pkg::*;
#(
   parameter int DATA_W        = BEAT_DATA_W,
   parameter int FIFO_DEPTH    = 512,
   parameter int MAX_PKT_BEATS = 24,
   parameter int SLACK         = 4
) (
   input  logic               clk,
   input  logic               rst_l,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sop,
   input  logic               in_eop,
   input  logic [EMPTY_W-1:0] in_empty,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_sop,
   output logic               out_eop,
   output logic [EMPTY_W-1:0] out_empty,
   input  logic [31:0]        fill_level,
   output logic [31:0]        pkt_cnt,
   output logic [31:0]        drop_cnt,
   output logic [31:0]        err_cnt
);

   // Worst-case packet plus report-latency slack must still fit above this level.
   localparam logic [31:0] ADMIT_LIMIT = 32'(FIFO_DEPTH - MAX_PKT_BEATS - SLACK);

   admit_state_t state_q, state_d;
   logic         xfer, admit, load, reg_ready;
   logic         inc_pkt, inc_drop, inc_err;
   beat_t        in_beat, out_beat;

   assign in_beat = '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty};
   assign xfer    = in_valid & in_ready;
   assign admit   = (fill_level <= ADMIT_LIMIT);

   // A dropped packet never touches the output register, so it is consumed
   // at full rate even while the FIFO is stalled.
   assign in_ready = (state_q == DROP) ? 1'b1 : reg_ready;

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      inc_pkt  = 1'b0;
      inc_drop = 1'b0;
      inc_err  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               if (in_sop) begin
                  if (admit) begin
                     load    = 1'b1;
                     inc_pkt = 1'b1;
                     if (!in_eop) state_d = PASS;
                  end else begin
                     inc_drop = 1'b1;
                     if (!in_eop) state_d = DROP;
                  end
               end else begin
                  inc_err = 1'b1;
               end
            end
         end
         PASS: begin
            if (xfer) begin
               load = 1'b1;
               // Stray sop is forwarded as-is; the packet keeps its original decision.
               if (in_sop) inc_err = 1'b1;
               if (in_eop) state_d = IDLE;
            end
         end
         DROP: begin
            if (xfer) begin
               if (in_sop) inc_err = 1'b1;
               if (in_eop) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Admission FSM stage
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state_q <= IDLE;
      else        state_q <= state_d;
   end

   pkt_admit_outreg u_outreg (
      .clk       (clk),
      .rst_l     (rst_l),
      .load      (load),
      .in_beat   (in_beat),
      .ready     (reg_ready),
      .out_valid (out_valid),
      .out_beat  (out_beat),
      .out_ready (out_ready)
   );

   assign out_data  = out_beat.data;
   assign out_sop   = out_beat.sop;
   assign out_eop   = out_beat.eop;
   assign out_empty = out_beat.empty;

`ifdef PKT_ADMIT_STATS_EN
   logic [31:0] pkt_cnt_q,  pkt_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic [31:0] err_cnt_q,  err_cnt_d;

   always_comb begin
      pkt_cnt_d  = pkt_cnt_q  + {31'd0, inc_pkt};
      drop_cnt_d = drop_cnt_q + {31'd0, inc_drop};
      err_cnt_d  = err_cnt_q  + {31'd0, inc_err};
   end

   // Statistics stage
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         pkt_cnt_q  <= 32'd0;
         drop_cnt_q <= 32'd0;
         err_cnt_q  <= 32'd0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign drop_cnt = drop_cnt_q;
   assign err_cnt  = err_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = ^{inc_pkt, inc_drop, inc_err};
   assign pkt_cnt  = 32'd0;
   assign drop_cnt = 32'd0;
   assign err_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_pkt_admit_drop.sv
// tb_pkt_admit_drop
//   Directed and randomized bench for pkt_admit_drop. A packet-level reference
//   model (per-packet keep/drop decision, queue of forwarded beats, counters)
//   predicts every output each cycle.
module tb_pkt_admit_drop;

   localparam int DATA_W      = 512;
   localparam int BW          = DATA_W + 8;
   localparam int ADMIT_LIMIT = 512 - 24 - 4;
`ifdef PKT_ADMIT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_l;
   logic [DATA_W-1:0] in_data;
   logic              in_valid, in_ready, in_sop, in_eop;
   logic [5:0]        in_empty;
   logic [DATA_W-1:0] out_data;
   logic              out_valid, out_ready, out_sop, out_eop;
   logic [5:0]        out_empty;
   logic [31:0]       fill_level, pkt_cnt, drop_cnt, err_cnt;

   always #5 clk = ~clk;

   pkt_admit_drop dut (
      .clk(clk), .rst_l(rst_l),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
      .fill_level(fill_level), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
   );

   int n_asserts = 0;
   int n_fails   = 0;

   // Reference model state
   logic [BW-1:0] q[$];
   bit            m_in_pkt, m_keep, last_acc, tog;
   logic [31:0]   m_pkt, m_drop, m_err;

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_in_pkt = 0; m_keep = 0;
      m_pkt = 0; m_drop = 0; m_err = 0;
   endtask

   function automatic logic [31:0] cexp(input logic [31:0] v);
      return STATS ? v : 32'd0;
   endfunction

   // Check all outputs mid-cycle, then advance the model over the coming edge.
   task automatic cycle();
      bit exp_ready, acc;
      logic [BW-1:0] beat;
      #2;
      exp_ready = (m_in_pkt && !m_keep) || (q.size() == 0) || out_ready;
      chk("in_ready", BW'(in_ready), BW'(exp_ready));
      chk("out_valid", BW'(out_valid), BW'(q.size() != 0));
      chk("out_beat", {out_data, out_sop, out_eop, out_empty}, (q.size() != 0) ? q[0] : '0);
      chk("pkt_cnt", BW'(pkt_cnt), BW'(cexp(m_pkt)));
      chk("drop_cnt", BW'(drop_cnt), BW'(cexp(m_drop)));
      chk("err_cnt", BW'(err_cnt), BW'(cexp(m_err)));
      beat = {in_data, in_sop, in_eop, in_empty};
      acc = in_valid && exp_ready;
      last_acc = acc;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (acc) begin
         if (!m_in_pkt) begin
            if (in_sop) begin
               m_keep = (fill_level <= ADMIT_LIMIT);
               if (m_keep) begin m_pkt++; q.push_back(beat); end
               else m_drop++;
               m_in_pkt = !in_eop;
            end else m_err++;
         end else begin
            if (in_sop) m_err++;
            if (m_keep) q.push_back(beat);
            if (in_eop) m_in_pkt = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 0; out_ready = 1;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic set_ready(input int mode);
      case (mode)
         0: out_ready = 1;
         1: out_ready = 0;
         2: begin out_ready = tog; tog = ~tog; end
         default: out_ready = $urandom_range(1);
      endcase
   endtask

   // Present n_sent beats of an n-beat packet; each beat is held until accepted.
   task automatic send_pkt(input int n, input int n_sent, input logic [31:0] f_sop,
                           input logic [31:0] f_mid, input int rdy_mode,
                           input int vld_pct, input bit bad_sop);
      for (int b = 0; b < n_sent; b++) begin
         int guard;
         for (int w = 0; w < DATA_W / 32; w++) in_data[w*32 +: 32] = $urandom;
         in_sop     = (b == 0) || (bad_sop && b == 1);
         in_eop     = (b == n - 1);
         in_empty   = 6'($urandom);
         fill_level = (b == 0) ? f_sop : f_mid;
         guard = 0;
         last_acc = 0;
         while (!last_acc && guard < 60) begin
            in_valid = ($urandom_range(99) < vld_pct);
            set_ready(rdy_mode);
            cycle();
            guard++;
         end
         if (!last_acc) chk("accept_timeout", BW'(0), BW'(1));
      end
      in_valid = 0; in_sop = 0; in_eop = 0;
   endtask

   initial begin
      model_reset();
      tog = 0;
      rst_l = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_empty = 0;
      in_data = '0; out_ready = 0; fill_level = 0;
      // Reset state
      #3;
      chk("rst_in_ready", BW'(in_ready), BW'(1));
      chk("rst_out_valid", BW'(out_valid), BW'(0));
      chk("rst_counters", BW'({pkt_cnt, drop_cnt, err_cnt}), BW'(0));
      @(negedge clk); rst_l = 1;
      @(posedge clk); #1;
      idle(2);

      // 1: admitted 3-beat packet at full rate
      send_pkt(3, 3, 0, 0, 0, 100, 0);
      idle(2);
      chk("t1_pkt_cnt", BW'(pkt_cnt), BW'(cexp(1)));

      // 2: dropped 5-beat packet, consumed even with the FIFO stalled
      send_pkt(5, 5, ADMIT_LIMIT + 1, 0, 1, 100, 0);
      idle(2);
      chk("t2_drop_cnt", BW'(drop_cnt), BW'(cexp(1)));

      // 3: admitted at exactly the limit; later fill changes are ignored
      send_pkt(6, 6, ADMIT_LIMIT, ADMIT_LIMIT + 50, 0, 100, 0);
      idle(2);
      chk("t3_pkt_cnt", BW'(pkt_cnt), BW'(cexp(2)));
      chk("t3_drop_cnt", BW'(drop_cnt), BW'(cexp(1)));

      // 4: out_ready toggling every cycle
      send_pkt(8, 8, 10, 10, 2, 100, 0);
      idle(3);

      // 5: stray beat in IDLE, then a normal packet
      in_valid = 1; in_sop = 0; in_eop = 0; out_ready = 1; in_data = '1;
      cycle();
      in_valid = 0;
      idle(1);
      chk("t5_err_cnt", BW'(err_cnt), BW'(cexp(1)));
      send_pkt(2, 2, 0, 0, 0, 100, 0);
      idle(2);

      // 6: asynchronous reset mid-packet
      send_pkt(4, 2, 0, 0, 0, 100, 0);
      out_ready = 0;
      #1 rst_l = 0;
      #1;
      model_reset();
      chk("t6_out_valid", BW'(out_valid), BW'(0));
      chk("t6_counters", BW'({pkt_cnt, drop_cnt, err_cnt}), BW'(0));
      @(negedge clk); rst_l = 1;
      @(posedge clk); #1;
      send_pkt(3, 3, 0, 0, 0, 100, 0);
      idle(2);
      chk("t6_pkt_cnt", BW'(pkt_cnt), BW'(cexp(1)));

      // Randomized traffic around the admission boundary
      for (int p = 0; p < 60; p++) begin
         int n;
         logic [31:0] fs;
         n = $urandom_range(1, 8);
         case ($urandom_range(3))
            0: fs = $urandom_range(0, ADMIT_LIMIT);
            1: fs = $urandom_range(ADMIT_LIMIT - 1, ADMIT_LIMIT + 1);
            2: fs = $urandom;
            default: fs = ADMIT_LIMIT + $urandom_range(0, 1);
         endcase
         if ($urandom_range(9) == 0) begin
            in_valid = 1; in_sop = 0; in_eop = $urandom_range(1); set_ready(3);
            cycle();
            in_valid = 0;
         end
         send_pkt(n, n, fs, $urandom, 3, 70, (n > 1) && ($urandom_range(9) == 0));
      end
      idle(4);
      chk("final_drained", BW'(q.size()), BW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
